// File: rtl/multi_cycle_adder_pkg.sv
// Shared types and sizing helpers for the chunked multi-cycle adder.
package adder_pkg;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    function automatic int unsigned nchunk(int unsigned width, int unsigned chunk);
        return (chunk == 0) ? 1 : width / chunk;
    endfunction

    // Index counter width; never below one bit so NCHUNK=1 still has a legal register.
    function automatic int unsigned idx_width(int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_cycle_adder_if.sv
// Operand/result valid-ready bundle between producer, adder and consumer.
interface multi_cycle_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, r, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, r, c_out, ovf
    );
endinterface

// File: rtl/multi_cycle_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from one-bit full-adder cells.
module chunk_adder #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);
    logic [CHUNK:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/multi_cycle_adder.sv
// Multi-cycle adder: CHUNK bits per clock with a registered inter-chunk carry.
// Optional subtract mode enabled by defining ADDER_SUB_EN.
module multi_cycle_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input logic                clk,
    input logic                rst,
    multi_cycle_adder_if.slave bus
);
    localparam int unsigned NChunk = nchunk(WIDTH, CHUNK);
    localparam int unsigned IdxW   = idx_width(NChunk);

    if (CHUNK == 0 || WIDTH == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("multi_cycle_adder: WIDTH must be a nonzero multiple of CHUNK");
    end

    state_e            state_q;
    logic [WIDTH-1:0]  a_q, b_q, r_q;
    logic [IdxW-1:0]   idx_q;
    logic              carry_q, in_ready_q, out_valid_q, c_out_q, ovf_q;

    int                base;
    logic [CHUNK-1:0]  a_chunk, b_chunk, sum;
    logic              chunk_co, chunk_cmsb, last;

    always_comb begin
        base    = int'(idx_q) * int'(CHUNK);
        a_chunk = a_q[base +: CHUNK];
        b_chunk = b_q[base +: CHUNK];
        last    = (idx_q == IdxW'(NChunk - 1));
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a     (a_chunk),
        .b     (b_chunk),
        .c_in  (carry_q),
        .sum   (sum),
        .c_out (chunk_co),
        .c_msb (chunk_cmsb)
    );

`ifdef ADDER_SUB_EN
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    always_comb begin
        b_eff = bus.sub ? ~bus.b : bus.b;
        c_eff = bus.sub | bus.c_in;
    end
`else
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             unused_sub;
    always_comb begin
        b_eff      = bus.b;
        c_eff      = bus.c_in;
        unused_sub = bus.sub;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= b_eff;
                        carry_q    <= c_eff;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StBusy;
                    end
                end
                StBusy: begin
                    r_q[base +: CHUNK] <= sum;
                    carry_q            <= chunk_co;
                    if (last) begin
                        idx_q       <= '0;
                        c_out_q     <= chunk_co;
                        // Signed overflow: carry into the MSB differs from carry out of it.
                        ovf_q       <= chunk_co ^ chunk_cmsb;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.r         = r_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
endmodule
